sdma_req_scheduler: RTL
=======================

// Module: sdma_req_scheduler
// PURPOSE
//  Round-robin scheduler sharing the cell macro's SDMA engine among NUM_CH fabric requesters
//  (UART RX/TX FIFOs, sensor FIFOs). Drives SDMA_Req[], tracks SDMA_Active/SDMA_Done per grant,
//  aborts requests the engine never accepts. Sits between FPGA IP FIFO-level flags and the
//  qlal4s3b_cell_macro SDMA port, in the WB_CLK domain.
// PARAMETERS
//  NUM_CH       4    number of requesters / SDMA channels (2..4)
//  TO_WIDTH     8    width of request-timeout counter
//  REQ_TIMEOUT  200  cycles SDMA_Req may stay high without SDMA_Active before abort (< 2**TO_WIDTH)
//  HOLDOFF      2    idle cycles after each grant ends before next arbitration (0 allowed)
// PORTS
//  WB_CLK       in   1       fabric clock (Sys_Clk0 via gclkbuff)
//  WB_RST_n     in   1       async active-low reset
//  req_i        in   NUM_CH  level request per channel (FIFO threshold reached)
//  en_i         in   NUM_CH  per-channel enable from register bank
//  err_clr_i    in   NUM_CH  1-cycle clear of sticky timeout flag
//  SDMA_Active  in   NUM_CH  engine accepted/is servicing channel
//  SDMA_Done    in   NUM_CH  engine transfer-complete pulse
//  SDMA_Req     out  NUM_CH  registered one-hot request to engine
//  grant_o      out  NUM_CH  one-hot current owner (REQ or ACTIVE state)
//  done_o       out  NUM_CH  1-cycle pulse when granted transfer completes
//  to_err_o     out  NUM_CH  sticky timeout flag per channel
//  busy_o       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, WB_RST_n=0): all outputs 0, state IDLE, rr pointer ptr=0, timer=0.
//  All outputs registered. eligible = req_i & en_i.
//  IDLE: if eligible!=0, pick first set bit scanning ptr, ptr+1, ... mod NUM_CH; latch g;
//    next edge: state REQ, SDMA_Req[g]=1, grant_o[g]=1, timer=0. Latency req->SDMA_Req: 1 cycle.
//  REQ: timer increments each cycle.
//    - SDMA_Done[g] (with or without Active): SDMA_Req=0, done_o[g] pulse, -> HOLD.
//    - else SDMA_Active[g]: SDMA_Req=0 next edge, -> ACTIVE.
//    - else en_i[g]=0: abort, SDMA_Req=0, no error, -> HOLD.
//    - else timer==REQ_TIMEOUT-1: SDMA_Req=0, to_err_o[g] set, -> HOLD
//      (SDMA_Req high exactly REQ_TIMEOUT cycles).
//  ACTIVE: no timeout, en_i ignored (engine transfer not cancellable).
//    SDMA_Done[g] -> done_o[g] pulse, grant_o=0, -> HOLD.
//  HOLD: grant_o=0; count HOLDOFF cycles then IDLE (HOLDOFF=0: IDLE next edge).
//  Every exit from REQ/ACTIVE sets ptr=(g+1) mod NUM_CH -> no channel starves under constant load.
//  Active/Done on channels != g, or in IDLE/HOLD: ignored.
//  req_i dropping after grant: no effect; grant runs to Done/timeout/abort.
//  to_err_o[k]: set on timeout, cleared by err_clr_i[k]; set wins when simultaneous.
//  At most one SDMA_Req bit and one grant_o bit high in any cycle.
// TESTING
//  1 req_i=0100, en_i=1111: SDMA_Req=0100 1 cycle later; Active[2] 3 cycles on -> SDMA_Req=0 next
//    edge; Done[2] pulse -> done_o=0100 one cycle; busy_o low after HOLDOFF+1 cycles.
//  2 req_i=1111 held, engine answers Active/Done promptly: grant order 0,1,2,3,0,1 with
//    HOLDOFF=2 idle gaps.
//  3 req_i=0010, no Active: SDMA_Req[1] high exactly 200 cycles, to_err_o=0010; with req_i=0110,
//    ch2 granted next; err_clr_i=0010 clears flag; simultaneous set+clear leaves it set.
//  4 en_i[0] dropped while ch0 in REQ -> SDMA_Req=0, no error, next eligible granted;
//    en_i[0] dropped in ACTIVE -> waits for Done.
//  5 WB_RST_n low during ACTIVE on ch3 -> all outputs 0 immediately; after release req_i=1111
//    grants ch0 first.
//  6 Done[1] while ch2 ACTIVE -> ignored; Active[0]+Done[0] same cycle in REQ -> done_o=0001,
//    no ACTIVE.

Source files
------------

// File: rtl/sdma_req_scheduler_if.sv
// SDMA engine request port between the scheduler and the cell macro.
// Handshake: SDMA_Req is the one-hot "valid" held by the master; SDMA_Active[k] is the engine's
// acceptance of channel k, and SDMA_Done[k] pulses once when that transfer completes.
interface sdma_req_scheduler_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] SDMA_Req;
   logic [NUM_CH-1:0] SDMA_Active;
   logic [NUM_CH-1:0] SDMA_Done;

   modport master (output SDMA_Req, input SDMA_Active, input SDMA_Done);
   modport slave  (input SDMA_Req, output SDMA_Active, output SDMA_Done);
endinterface

// File: rtl/sdma_req_scheduler.sv
// Round-robin scheduler sharing one SDMA engine among NUM_CH fabric requesters,
// with request timeout/abort and a holdoff gap after each grant.
module sdma_req_scheduler #(
   parameter int NUM_CH      = 4,
   parameter int TO_WIDTH    = 8,
   parameter int REQ_TIMEOUT = 200,
   parameter int HOLDOFF     = 2
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST_n,
   input  logic [NUM_CH-1:0]    req_i,
   input  logic [NUM_CH-1:0]    en_i,
   input  logic [NUM_CH-1:0]    err_clr_i,
   sdma_req_scheduler_if.master sdma,
   output logic [NUM_CH-1:0]    grant_o,
   output logic [NUM_CH-1:0]    done_o,
   output logic [NUM_CH-1:0]    to_err_o,
   output logic                 busy_o,
   output logic [1:0]           dbg_state_o
);
   localparam int CW = $clog2(NUM_CH);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(REQ_TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST = (HOLDOFF == 0) ? '0 : HW'(HOLDOFF - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACTIVE = 2'd2, HOLD = 2'd3} state_t;
   localparam state_t EXIT_STATE = (HOLDOFF == 0) ? IDLE : HOLD;

   state_t              state_q;
   logic [CW-1:0]       g_q;
   logic [CW-1:0]       ptr_q;
   logic [TO_WIDTH-1:0] timer_q;
   logic [HW-1:0]       hold_cnt_q;
   logic [NUM_CH-1:0]   sdma_req_q;
   logic [NUM_CH-1:0]   grant_q;
   logic [NUM_CH-1:0]   done_q;
   logic [NUM_CH-1:0]   to_err_q;
   logic                busy_q;

   logic [NUM_CH-1:0]   eligible;
   logic [NUM_CH-1:0]   g_oh;
   logic [NUM_CH-1:0]   pick_oh;
   logic [NUM_CH-1:0]   to_set;
   logic [CW-1:0]       pick;
   logic [CW-1:0]       ptr_next;
   logic [CW:0]         idx;
   logic                pick_valid;

   assign eligible = req_i & en_i;
   assign g_oh     = NUM_CH'(1) << g_q;
   assign pick_oh  = NUM_CH'(1) << pick;
   assign ptr_next = (g_q == CW'(NUM_CH - 1)) ? '0 : g_q + CW'(1);

   // Scan descending so the smallest offset from ptr_q is the last (winning) assignment.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      idx        = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = {1'b0, ptr_q} + (CW + 1)'(i);
         if (idx >= (CW + 1)'(NUM_CH)) idx = idx - (CW + 1)'(NUM_CH);
         if (eligible[idx[CW-1:0]]) begin
            pick_valid = 1'b1;
            pick       = idx[CW-1:0];
         end
      end
   end

   always_comb begin
      to_set = '0;
      if (state_q == REQ && !sdma.SDMA_Done[g_q] && !sdma.SDMA_Active[g_q] &&
          en_i[g_q] && timer_q == TO_LAST)
         to_set = g_oh;
   end

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         state_q    <= IDLE;
         g_q        <= '0;
         ptr_q      <= '0;
         timer_q    <= '0;
         hold_cnt_q <= '0;
         sdma_req_q <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         to_err_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         done_q   <= '0;
         // A timeout set in the same cycle as a clear must survive.
         to_err_q <= (to_err_q & ~err_clr_i) | to_set;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q    <= REQ;
                  g_q        <= pick;
                  sdma_req_q <= pick_oh;
                  grant_q    <= pick_oh;
                  timer_q    <= '0;
                  busy_q     <= 1'b1;
               end
            end
            REQ: begin
               timer_q <= timer_q + TO_WIDTH'(1);
               if (sdma.SDMA_Done[g_q]) begin
                  sdma_req_q <= '0;
                  grant_q    <= '0;
                  done_q     <= g_oh;
                  state_q    <= EXIT_STATE;
                  busy_q     <= (EXIT_STATE != IDLE);
                  hold_cnt_q <= '0;
                  ptr_q      <= ptr_next;
               end else if (sdma.SDMA_Active[g_q]) begin
                  sdma_req_q <= '0;
                  state_q    <= ACTIVE;
               end else if (!en_i[g_q] || timer_q == TO_LAST) begin
                  sdma_req_q <= '0;
                  grant_q    <= '0;
                  state_q    <= EXIT_STATE;
                  busy_q     <= (EXIT_STATE != IDLE);
                  hold_cnt_q <= '0;
                  ptr_q      <= ptr_next;
               end
            end
            ACTIVE: begin
               if (sdma.SDMA_Done[g_q]) begin
                  grant_q    <= '0;
                  done_q     <= g_oh;
                  state_q    <= EXIT_STATE;
                  busy_q     <= (EXIT_STATE != IDLE);
                  hold_cnt_q <= '0;
                  ptr_q      <= ptr_next;
               end
            end
            HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sdma.SDMA_Req = sdma_req_q;
   assign grant_o       = grant_q;
   assign done_o        = done_q;
   assign to_err_o      = to_err_q;
   assign busy_o        = busy_q;
   assign dbg_state_o   = state_q;
endmodule
